// File: rtl/dino_game_sequencer_if.sv
// Control/status bundle between the dino game sequencer and its environment.
// master drives the frame tick, button and collision flag; slave is the sequencer.
interface dino_game_sequencer_if;
  logic        frame_tick;
  logic        up;
  logic        collision;
  logic [2:0]  state;
  logic        world_clear;
  logic        spawn;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        jump;

  modport master (
    output frame_tick, up, collision,
    input  state, world_clear, spawn, speed, score, jump
  );

  modport slave (
    input  frame_tick, up, collision,
    output state, world_clear, spawn, speed, score, jump
  );
endinterface

// File: rtl/dino_game_sequencer.sv
// Dino runner game sequencer: INIT/PLAY/DONE control, scoring, speed ramp and
// LFSR-randomised obstacle spawn scheduling. All outputs are registered.
module dino_game_sequencer #(
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned SPEED_STEP       = 100,
  parameter logic [3:0]  SPEED_MIN        = 4'd2,
  parameter logic [3:0]  SPEED_MAX        = 4'd8,
  parameter logic [7:0]  GAP_MIN          = 8'd40,
  parameter logic [7:0]  GAP_MASK         = 8'h3F,
  parameter int unsigned DONE_HOLD        = 30,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst,
  dino_game_sequencer_if.slave  bus
);

  localparam int unsigned FDW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int unsigned SCW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int unsigned HDW = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;

  localparam logic [FDW-1:0] FD_LAST   = FDW'(FRAMES_PER_POINT - 1);
  localparam logic [SCW-1:0] SC_LAST   = SCW'(SPEED_STEP - 1);
  localparam logic [HDW-1:0] HOLD_LOAD = HDW'(DONE_HOLD);

  typedef enum logic [2:0] {
    S_INIT = 3'b001,
    S_PLAY = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           up_q;
  logic [FDW-1:0] frame_div_q, frame_div_d;
  logic [SCW-1:0] step_q, step_d;
  logic [7:0]     gap_q, gap_d;
  logic [HDW-1:0] hold_q, hold_d;
  logic [15:0]    score_q, score_d;
  logic [3:0]     speed_q, speed_d;
  logic           spawn_q, spawn_d;
  logic           jump_q, jump_d;
  logic           world_clear_q, world_clear_d;
  logic           up_edge;
  logic           clear_game;

  assign up_edge = bus.up & ~up_q;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    frame_div_d   = frame_div_q;
    step_d        = step_q;
    gap_d         = gap_q;
    hold_d        = hold_q;
    score_d       = score_q;
    speed_d       = speed_q;
    spawn_d       = 1'b0;
    jump_d        = 1'b0;
    world_clear_d = 1'b0;
    clear_game    = 1'b0;

    case (state_q)
      S_INIT: begin
        world_clear_d = 1'b1;
        clear_game    = 1'b1;
        if (up_edge) begin
          state_d       = S_PLAY;
          world_clear_d = 1'b0;
        end
      end
      S_PLAY: begin
        if (bus.collision) begin
          state_d = S_DONE;
          hold_d  = HOLD_LOAD;
        end else begin
          jump_d = up_edge;
          if (bus.frame_tick) begin
            if (frame_div_q == FD_LAST) begin
              frame_div_d = '0;
              // step_q tracks score mod SPEED_STEP so no divider is needed
              if (score_q != '1) begin
                score_d = score_q + 16'd1;
                if (step_q == SC_LAST) begin
                  step_d = '0;
                  if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
                end else begin
                  step_d = step_q + 1'b1;
                end
              end
            end else begin
              frame_div_d = frame_div_q + 1'b1;
            end
            if (gap_q != '0) begin
              gap_d = gap_q - 8'd1;
            end else begin
              spawn_d = 1'b1;
              gap_d   = GAP_MIN + (lfsr_q[7:0] & GAP_MASK);
            end
          end
        end
      end
      S_DONE: begin
        if (bus.frame_tick && hold_q != '0) hold_d = hold_q - 1'b1;
        if (up_edge && hold_q == '0) begin
          state_d       = S_INIT;
          world_clear_d = 1'b1;
          clear_game    = 1'b1;
        end
      end
      default: begin
        state_d       = S_INIT;
        world_clear_d = 1'b1;
        clear_game    = 1'b1;
      end
    endcase

    if (clear_game) begin
      frame_div_d = '0;
      step_d      = '0;
      gap_d       = GAP_MIN;
      score_d     = '0;
      speed_d     = SPEED_MIN;
      if (state_d != S_DONE) hold_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      lfsr_q        <= LFSR_SEED;
      up_q          <= 1'b0;
      frame_div_q   <= '0;
      step_q        <= '0;
      gap_q         <= GAP_MIN;
      hold_q        <= '0;
      score_q       <= '0;
      speed_q       <= SPEED_MIN;
      spawn_q       <= 1'b0;
      jump_q        <= 1'b0;
      world_clear_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      up_q          <= bus.up;
      frame_div_q   <= frame_div_d;
      step_q        <= step_d;
      gap_q         <= gap_d;
      hold_q        <= hold_d;
      score_q       <= score_d;
      speed_q       <= speed_d;
      spawn_q       <= spawn_d;
      jump_q        <= jump_d;
      world_clear_q <= world_clear_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.world_clear = world_clear_q;
  assign bus.spawn       = spawn_q;
  assign bus.speed       = speed_q;
  assign bus.score       = score_q;
  assign bus.jump        = jump_q;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Scoreboard bench: stimulus queues expected snapshots/pulse cycles, a negedge
// monitor pops and compares them against the two sequencer instances.
module tb_dino_game_sequencer;

  logic clk;
  logic rst;
  int   cyc = 0;

  dino_game_sequencer_if b1 ();
  dino_game_sequencer_if b2 ();

  dino_game_sequencer #(
    .FRAMES_PER_POINT(2), .SPEED_STEP(3), .SPEED_MIN(4'd2), .SPEED_MAX(4'd4),
    .GAP_MIN(8'd3), .GAP_MASK(8'h00), .DONE_HOLD(5), .LFSR_SEED(16'hACE1)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  dino_game_sequencer #(
    .FRAMES_PER_POINT(1), .SPEED_STEP(100), .SPEED_MIN(4'd2), .SPEED_MAX(4'd8),
    .GAP_MIN(8'd3), .GAP_MASK(8'h3F), .DONE_HOLD(30), .LFSR_SEED(16'hACE1)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    string       name;
    logic [2:0]  st;
    logic [15:0] sc;
    logic [3:0]  sp;
    logic        wc;
  } snap_t;

  snap_t snap_q[$];
  int    spawn_q[$];
  int    jump_q[$];
  int    checks = 0;
  int    passed = 0;
  int    model_ticks = 0;
  bit    model_play = 0;
  int    last2 = -1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input int inst, input string name, input logic [2:0] st,
                      input logic [15:0] sc, input logic [3:0] sp, input logic wc);
    snap_t s;
    s.inst = inst; s.name = name; s.st = st; s.sc = sc; s.sp = sp; s.wc = wc;
    snap_q.push_back(s);
  endtask

  // One-clk frame tick on u1; in PLAY every 4th tick must yield a spawn next cycle.
  task automatic tick();
    b1.frame_tick = 1'b1;
    if (model_play) begin
      model_ticks++;
      if (model_ticks % 4 == 0) spawn_q.push_back(cyc + 1);
    end
    step(1);
    b1.frame_tick = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    snap_t       s;
    logic [2:0]  a_st;
    logic [15:0] a_sc;
    logic [3:0]  a_sp;
    logic        a_wc;
    int          e;
    int          g;
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      if (s.inst == 1) begin
        a_st = b1.state; a_sc = b1.score; a_sp = b1.speed; a_wc = b1.world_clear;
      end else begin
        a_st = b2.state; a_sc = b2.score; a_sp = b2.speed; a_wc = b2.world_clear;
      end
      checks++;
      if (a_st === s.st && a_sc === s.sc && a_sp === s.sp && a_wc === s.wc) passed++;
      else $display("FAIL %s: got state=%b score=%h speed=%0d wc=%b, want state=%b score=%h speed=%0d wc=%b",
                    s.name, a_st, a_sc, a_sp, a_wc, s.st, s.sc, s.sp, s.wc);
    end
    if (b1.spawn === 1'b1) begin
      checks++;
      if (spawn_q.size() == 0) $display("FAIL spawn: unexpected pulse at cycle %0d, want none", cyc);
      else begin
        e = spawn_q.pop_front();
        if (e == cyc) passed++;
        else $display("FAIL spawn: pulse at cycle %0d, want cycle %0d", cyc, e);
      end
    end
    if (b1.jump === 1'b1) begin
      checks++;
      if (jump_q.size() == 0) $display("FAIL jump: unexpected pulse at cycle %0d, want none", cyc);
      else begin
        e = jump_q.pop_front();
        if (e == cyc) passed++;
        else $display("FAIL jump: pulse at cycle %0d, want cycle %0d", cyc, e);
      end
    end
    if (b2.spawn === 1'b1) begin
      if (last2 >= 0) begin
        g = cyc - last2 - 1;
        checks++;
        if (g >= 3 && g <= 66) passed++;
        else $display("FAIL random_gap: gap %0d frames at cycle %0d, want 3..66", g, cyc);
      end
      last2 = cyc;
    end
  end

  initial begin
    rst = 1'b1;
    b1.frame_tick = 1'b0; b1.up = 1'b0; b1.collision = 1'b0;
    b2.frame_tick = 1'b0; b2.up = 1'b0; b2.collision = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    snap(1, "reset", 3'b001, 16'd0, 4'd2, 1'b1);

    tick();
    snap(1, "init_tick_ignored", 3'b001, 16'd0, 4'd2, 1'b1);

    b1.up = 1'b1;
    step(1);
    b1.up = 1'b0;
    model_play = 1; model_ticks = 0;
    snap(1, "start", 3'b010, 16'd0, 4'd2, 1'b0);
    step(1);

    repeat (6) tick();
    snap(1, "score3_speed3", 3'b010, 16'd3, 4'd3, 1'b0);
    repeat (14) tick();
    snap(1, "score10_speed_sat", 3'b010, 16'd10, 4'd4, 1'b0);

    b1.up = 1'b1;
    jump_q.push_back(cyc + 1);
    step(10);
    b1.up = 1'b0;
    step(1);
    snap(1, "after_jump", 3'b010, 16'd10, 4'd4, 1'b0);

    tick();
    b1.collision = 1'b1; b1.frame_tick = 1'b1; b1.up = 1'b1;
    model_play = 0;
    step(1);
    b1.frame_tick = 1'b0;
    snap(1, "collision_priority", 3'b100, 16'd10, 4'd4, 1'b0);
    step(2);
    b1.collision = 1'b0; b1.up = 1'b0;
    step(1);

    repeat (3) tick();
    b1.up = 1'b1;
    step(1);
    b1.up = 1'b0;
    step(1);
    snap(1, "done_hold_ignores_up", 3'b100, 16'd10, 4'd4, 1'b0);
    repeat (2) tick();
    b1.up = 1'b1;
    step(1);
    b1.up = 1'b0;
    snap(1, "done_to_init", 3'b001, 16'd0, 4'd2, 1'b1);
    step(1);

    b1.up = 1'b1;
    step(1);
    b1.up = 1'b0;
    model_play = 1; model_ticks = 0;
    snap(1, "restart", 3'b010, 16'd0, 4'd2, 1'b0);
    step(1);
    repeat (4) tick();
    snap(1, "restart_score2", 3'b010, 16'd2, 4'd2, 1'b0);
    step(1);
    #2;
    rst = 1'b1;
    model_play = 0;
    snap(1, "async_reset_mid_play", 3'b001, 16'd0, 4'd2, 1'b1);
    step(2);
    rst = 1'b0;
    step(1);

    b2.up = 1'b1;
    step(1);
    b2.up = 1'b0;
    b2.frame_tick = 1'b1;
    snap(2, "u2_start", 3'b010, 16'd0, 4'd2, 1'b0);
    step(65600);
    snap(2, "u2_score_saturated", 3'b010, 16'hFFFF, 4'd8, 1'b0);
    step(20);
    snap(2, "u2_score_stays_sat", 3'b010, 16'hFFFF, 4'd8, 1'b0);
    b2.frame_tick = 1'b0;
    step(2);

    checks++;
    if (spawn_q.size() == 0) passed++;
    else $display("FAIL missing_spawn: %0d expected pulses not seen, want 0", spawn_q.size());
    checks++;
    if (jump_q.size() == 0) passed++;
    else $display("FAIL missing_jump: %0d expected pulses not seen, want 0", jump_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
